// File: rtl/core_defs_pkg.sv
// Shared definitions for the core memory-port arbiter: bus widths,
// arbiter state encoding and the byte-enable selection helper.
package core_defs_pkg;

  localparam int XLEN = 64;
  localparam int BE_W = 8;

  // Arbiter states; the grant owner is implied by the BUSY flavour.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_e;

  localparam logic [BE_W-1:0] BE_ALL = 8'hFF;

  // Reads always drive every byte lane; writes use the requester's enables.
  function automatic logic [BE_W-1:0] bus_be_for(input logic rw, input logic [BE_W-1:0] be);
    logic [BE_W-1:0] res;
    if (rw) begin
      res = be;
    end else begin
      res = BE_ALL;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating 4-bit counter that records how many data grants fetch has
// been made to wait through. Clear has priority over increment.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q >= MAX_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the core memory port between instruction fetch and the MEM-stage
// data requester. Data has priority; once fetch has waited through
// STARVE_MAX data grants it is guaranteed the next grant. One transaction
// is outstanding at a time; ack and read data are routed to its owner.
module mem_bus_arbiter
  import core_defs_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [63:0]     if_addr_i,
  output logic            if_ack_o,
  output logic [63:0]     if_rdata_o,
  input  logic            mem_valid_i,
  input  logic            mem_rw_i,
  input  logic [63:0]     mem_addr_i,
  input  logic [63:0]     mem_data_i,
  input  logic [7:0]      mem_data_byte_valid_i,
  output logic            mem_ack_o,
  output logic [63:0]     mem_rdata_o,
  output logic            bus_req_o,
  output logic            bus_rw_o,
  output logic [63:0]     bus_addr_o,
  output logic [63:0]     bus_wdata_o,
  output logic [7:0]      bus_be_o,
  input  logic            bus_ack_i,
  input  logic [63:0]     bus_rdata_i,
  output logic            stall_if_o,
  output logic            stall_mem_o
);

  arb_state_e            state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_rw_q, bus_rw_d;
  logic [XLEN-1:0]       bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]       bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0]       bus_be_q, bus_be_d;

  logic                  starve_sat_s;
  logic                  cnt_inc_s;
  logic                  cnt_clr_s;
  logic                  take_d_s;
  logic                  if_ack_s;
  logic                  mem_ack_s;

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc_s),
    .clr_i (cnt_clr_s),
    .sat_o (starve_sat_s)
  );

  // Data wins in IDLE unless fetch is waiting and the starvation limit is hit.
  assign take_d_s = mem_valid_i && (!starve_sat_s || !if_req_i);

  // Next-state, bus field capture and starvation counter control.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    cnt_inc_s   = 1'b0;
    cnt_clr_s   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (take_d_s) begin
          state_d     = ARB_BUSY_D;
          bus_req_d   = 1'b1;
          bus_rw_d    = mem_rw_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_data_i;
          bus_be_d    = bus_be_for(mem_rw_i, mem_data_byte_valid_i);
          cnt_inc_s   = if_req_i;
        end else if (if_req_i) begin
          state_d     = ARB_BUSY_I;
          bus_req_d   = 1'b1;
          bus_rw_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = {XLEN{1'b0}};
          bus_be_d    = BE_ALL;
          cnt_clr_s   = 1'b1;
        end else begin
          state_d     = ARB_IDLE;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus_ack_i) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
        end else begin
          state_d   = state_q;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered bus fields, dropped asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= {XLEN{1'b0}};
      bus_wdata_q <= {XLEN{1'b0}};
      bus_be_q    <= {BE_W{1'b0}};
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  // Completion is routed to the owner in the same cycle as the slave ack.
  always_comb begin
    if_ack_s  = (state_q == ARB_BUSY_I) && bus_ack_i;
    mem_ack_s = (state_q == ARB_BUSY_D) && bus_ack_i;
  end

  assign if_ack_o    = if_ack_s;
  assign mem_ack_o   = mem_ack_s;
  assign if_rdata_o  = if_ack_s  ? bus_rdata_i : {XLEN{1'b0}};
  assign mem_rdata_o = mem_ack_s ? bus_rdata_i : {XLEN{1'b0}};
  assign stall_if_o  = if_req_i && !if_ack_s;
  assign stall_mem_o = mem_valid_i && !mem_ack_s;

  assign bus_req_o   = bus_req_q;
  assign bus_rw_o    = bus_rw_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: hand-computed vector table, multi-cycle corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int SM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, mem_valid = 1'b0, mem_rw = 1'b0, bus_ack = 1'b0;
  logic [63:0] if_addr = 64'h0, mem_addr = 64'h0, mem_data = 64'h0, bus_rdata = 64'h0;
  logic [7:0]  mem_be = 8'h0;
  logic        if_ack_o, mem_ack_o, bus_req_o, bus_rw_o, stall_if_o, stall_mem_o;
  logic [63:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic [7:0]  bus_be_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .mem_valid_i(mem_valid), .mem_rw_i(mem_rw), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .mem_data_byte_valid_i(mem_be), .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_rw_o(bus_rw_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ack_i(bus_ack),
    .bus_rdata_i(bus_rdata), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one outstanding transaction) ----------
  int          m_owner;   // 0 none, 1 fetch, 2 data
  int          m_cnt;     // data grants fetch has waited through
  logic        m_req, m_rw;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_req = 1'b0; m_rw = 1'b0;
    m_addr = 64'h0; m_wdata = 64'h0; m_be = 8'h0;
  endtask

  task automatic grant_data();
    m_owner = 2; m_req = 1'b1; m_rw = mem_rw; m_addr = mem_addr; m_wdata = mem_data;
    m_be = mem_rw ? mem_be : 8'hFF;
    if (if_req) m_cnt = (m_cnt + 1 > SM) ? SM : m_cnt + 1;
  endtask

  task automatic grant_fetch();
    m_owner = 1; m_req = 1'b1; m_rw = 1'b0; m_addr = if_addr; m_wdata = 64'h0;
    m_be = 8'hFF; m_cnt = 0;
  endtask

  task automatic model_update();
    if (!rst) begin
      model_reset();
    end else if (m_owner != 0) begin
      if (bus_ack) begin m_owner = 0; m_req = 1'b0; end
    end else if (mem_valid && m_cnt < SM) begin
      grant_data();
    end else if (if_req) begin
      grant_fetch();
    end else if (mem_valid) begin
      grant_data();
    end
  endtask

  task automatic check_model();
    logic e_if_ack, e_mem_ack;
    e_if_ack  = (m_owner == 1) && bus_ack;
    e_mem_ack = (m_owner == 2) && bus_ack;
    chk("model.bus_req", bus_req_o, m_req);
    if (m_req) begin
      chk("model.bus_rw", bus_rw_o, m_rw);
      chk("model.bus_addr", bus_addr_o, m_addr);
      chk("model.bus_wdata", bus_wdata_o, m_wdata);
      chk("model.bus_be", bus_be_o, m_be);
    end
    chk("model.if_ack", if_ack_o, e_if_ack);
    chk("model.mem_ack", mem_ack_o, e_mem_ack);
    chk("model.if_rdata", if_rdata_o, e_if_ack ? bus_rdata : 64'h0);
    chk("model.mem_rdata", mem_rdata_o, e_mem_ack ? bus_rdata : 64'h0);
    chk("model.stall_if", stall_if_o, if_req && !e_if_ack);
    chk("model.stall_mem", stall_mem_o, mem_valid && !e_mem_ack);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic if_req; logic [63:0] if_addr;
    logic mem_valid, mem_rw; logic [63:0] mem_addr, mem_data; logic [7:0] mem_be;
    logic bus_ack; logic [63:0] bus_rdata;
    logic e_req, e_rw; logic [63:0] e_addr, e_wdata; logic [7:0] e_be;
    logic e_if_ack; logic [63:0] e_if_rdata; logic e_mem_ack; logic [63:0] e_mem_rdata;
    logic e_stall_if, e_stall_mem;
  } vec_t;

  vec_t tbl[11];
  int   row_idx = -1;

  task automatic check_row(input int i);
    chk($sformatf("vec%0d.bus_req", i), bus_req_o, tbl[i].e_req);
    if (tbl[i].e_req) begin
      chk($sformatf("vec%0d.bus_rw", i), bus_rw_o, tbl[i].e_rw);
      chk($sformatf("vec%0d.bus_addr", i), bus_addr_o, tbl[i].e_addr);
      chk($sformatf("vec%0d.bus_wdata", i), bus_wdata_o, tbl[i].e_wdata);
      chk($sformatf("vec%0d.bus_be", i), bus_be_o, tbl[i].e_be);
    end
    chk($sformatf("vec%0d.if_ack", i), if_ack_o, tbl[i].e_if_ack);
    chk($sformatf("vec%0d.if_rdata", i), if_rdata_o, tbl[i].e_if_rdata);
    chk($sformatf("vec%0d.mem_ack", i), mem_ack_o, tbl[i].e_mem_ack);
    chk($sformatf("vec%0d.mem_rdata", i), mem_rdata_o, tbl[i].e_mem_rdata);
    chk($sformatf("vec%0d.stall_if", i), stall_if_o, tbl[i].e_stall_if);
    chk($sformatf("vec%0d.stall_mem", i), stall_mem_o, tbl[i].e_stall_mem);
  endtask

  logic seen_if_ack = 1'b0, seen_mem_ack = 1'b0;
  int   mem_ack_pulses = 0;

  // One clock: check at the falling edge, advance the model at the rising
  // edge, return 1 time unit later so callers drive the next inputs.
  task automatic step();
    @(negedge clk);
    check_model();
    if (row_idx >= 0) check_row(row_idx);
    seen_if_ack  = if_ack_o;
    seen_mem_ack = mem_ack_o;
    if (mem_ack_o) mem_ack_pulses++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; mem_valid = 1'b0; mem_rw = 1'b0; bus_ack = 1'b0;
    if_addr = 64'h0; mem_addr = 64'h0; mem_data = 64'h0; mem_be = 8'h0; bus_rdata = 64'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[$];
    int exp_order[6];
    int n;
    logic [63:0] a;

    tbl[0]  = '{1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0,
                1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'hAAAA_5555_0000_1111,
                1'b1, 1'b0, 64'h1000, 64'h0, 8'hFF, 1'b1, 64'hAAAA_5555_0000_1111, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h2008, 64'hDEADBEEF, 8'h0F, 1'b1, 64'h5555,
                1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h2008, 64'hDEADBEEF, 8'h0F, 1'b0, 64'h0,
                1'b1, 1'b1, 64'h2008, 64'hDEADBEEF, 8'h0F, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h2008, 64'hDEADBEEF, 8'h0F, 1'b0, 64'h77,
                1'b1, 1'b1, 64'h2008, 64'hDEADBEEF, 8'h0F, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h2008, 64'hDEADBEEF, 8'h0F, 1'b1, 64'h1234,
                1'b1, 1'b1, 64'h2008, 64'hDEADBEEF, 8'h0F, 1'b0, 64'h0, 1'b1, 64'h1234, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h3000, 64'h0, 8'h0F, 1'b0, 64'h0,
                1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 64'h4000, 1'b1, 1'b0, 64'h3000, 64'h0, 8'h0F, 1'b0, 64'h0,
                1'b1, 1'b0, 64'h3000, 64'h0, 8'hFF, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 64'h4000, 1'b1, 1'b0, 64'h3000, 64'h0, 8'h0F, 1'b1, 64'hBEEF,
                1'b1, 1'b0, 64'h3000, 64'h0, 8'hFF, 1'b0, 64'h0, 1'b1, 64'hBEEF, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 64'h4000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0,
                1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 64'h4000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 64'h42,
                1'b1, 1'b0, 64'h4000, 64'h0, 8'hFF, 1'b1, 64'h42, 1'b0, 64'h0, 1'b0, 1'b0};

    // Reset state, with requests and a slave ack present during reset.
    model_reset();
    if_req = 1'b1; mem_valid = 1'b1; bus_ack = 1'b1; bus_rdata = 64'h99;
    @(negedge clk);
    chk("reset.bus_req", bus_req_o, 1'b0);
    chk("reset.bus_rw", bus_rw_o, 1'b0);
    chk("reset.bus_addr", bus_addr_o, 64'h0);
    chk("reset.bus_wdata", bus_wdata_o, 64'h0);
    chk("reset.bus_be", bus_be_o, 8'h00);
    chk("reset.if_ack", if_ack_o, 1'b0);
    chk("reset.mem_ack", mem_ack_o, 1'b0);
    chk("reset.mem_rdata", mem_rdata_o, 64'h0);
    chk("reset.stall_if", stall_if_o, 1'b1);
    chk("reset.stall_mem", stall_mem_o, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      mem_valid = tbl[i].mem_valid; mem_rw = tbl[i].mem_rw; mem_addr = tbl[i].mem_addr;
      mem_data = tbl[i].mem_data; mem_be = tbl[i].mem_be;
      bus_ack = tbl[i].bus_ack; bus_rdata = tbl[i].bus_rdata;
      row_idx = i;
      step();
    end
    row_idx = -1;
    idle_inputs();
    step();

    // Starvation: both held, zero-wait slave -> data, data, fetch, repeated.
    exp_order = '{2, 2, 1, 2, 2, 1};
    if_req = 1'b1; if_addr = 64'hF000;
    mem_valid = 1'b1; mem_rw = 1'b0; mem_addr = 64'hD000; mem_data = 64'h0; mem_be = 8'hFF;
    n = 0;
    while (order.size() < 6 && n < 40) begin
      bus_ack = bus_req_o;
      bus_rdata = 64'(n);
      if (bus_req_o) order.push_back((bus_addr_o == 64'hD000) ? 2 : 1);
      step();
      n++;
    end
    chk("starve.grant_count", 64'(order.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) chk($sformatf("starve.owner%0d", i), 64'(order[i]), 64'(exp_order[i]));
    end
    idle_inputs();
    step();

    // Slave waits 5 cycles on a data write.
    mem_valid = 1'b1; mem_rw = 1'b1; mem_addr = 64'h5000;
    mem_data = 64'h0123_4567_89AB_CDEF; mem_be = 8'h3C;
    mem_ack_pulses = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wait.addr%0d", i), bus_addr_o, 64'h5000);
      chk($sformatf("wait.stall%0d", i), stall_mem_o, 1'b1);
      step();
    end
    bus_ack = 1'b1; bus_rdata = 64'h55;
    step();
    idle_inputs();
    step(); step();
    chk("wait.ack_count", 64'(mem_ack_pulses), 64'd1);

    // Reset during BUSY_D with the starvation counter saturated.
    if_req = 1'b1; if_addr = 64'hF000;
    mem_valid = 1'b1; mem_rw = 1'b0; mem_addr = 64'hD000; mem_be = 8'hFF;
    step();
    bus_ack = 1'b1; step();
    bus_ack = 1'b0; step();
    chk("rst.pre_busy", bus_req_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst.async_bus_req", bus_req_o, 1'b0);
    model_reset();
    idle_inputs();
    step(); step();
    rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 64'h77;
    step();
    bus_ack = 1'b0;
    step();
    chk("rst.stray_ack_no_grant", bus_req_o, 1'b0);
    if_req = 1'b1; if_addr = 64'hF000;
    mem_valid = 1'b1; mem_rw = 1'b0; mem_addr = 64'hD000; mem_be = 8'hFF;
    step();
    chk("rst.cnt_cleared_data_wins", bus_addr_o, 64'hD000);
    bus_ack = 1'b1; step();
    mem_valid = 1'b0; bus_ack = 1'b0;
    step();
    bus_ack = 1'b1; step();
    idle_inputs();
    step();

    // Randomized traffic obeying the request-hold protocol.
    for (int c = 0; c < 500; c++) begin
      if (if_req) begin
        if (seen_if_ack) begin
          if_req = 1'($urandom_range(0, 1));
          if_addr = {$urandom(), $urandom()};
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = {$urandom(), $urandom()};
      end
      if (!mem_valid || seen_mem_ack) begin
        a = {$urandom(), $urandom()};
        if (mem_valid || $urandom_range(0, 2) == 0) begin
          mem_valid = 1'($urandom_range(0, 1)) | !mem_valid;
          mem_rw = 1'($urandom_range(0, 1));
          mem_addr = a;
          mem_data = {$urandom(), $urandom()};
          mem_be = 8'($urandom());
        end
      end
      bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = {$urandom(), $urandom()};
      step();
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single core memory port between the instruction-fetch requester and the MEM-stage data requester. Registers the winning request onto the bus, tracks the one outstanding transaction, and routes the acknowledge and read data back to the owner. Produces per-requester stall requests consumed by the pipeline control, which gates the stall inputs of the pipeline registers. Data requests have priority, and a starvation counter bounds how long fetch can be locked out.

## Interface
- STARVE_MAX, 4: consecutive data grants while fetch is waiting before fetch is forced to win; legal range 1..15.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held high until if_ack_o.
- if_addr_i  in  64  fetch address; held stable while if_req_i is high.
- if_ack_o  out  1  fetch transaction complete this cycle.
- if_rdata_o  out  64  fetch read data; valid when if_ack_o is high.
- mem_valid_i  in  1  data request; held high until mem_ack_o.
- mem_rw_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  64  data address.
- mem_data_i  in  64  write data.
- mem_data_byte_valid_i  in  8  write byte enables; ignored on reads.
- mem_ack_o  out  1  data transaction complete this cycle.
- mem_rdata_o  out  64  data read data; valid when mem_ack_o is high.
- bus_req_o  out  1  bus request, registered.
- bus_rw_o  out  1  bus direction, registered.
- bus_addr_o  out  64  bus address, registered.
- bus_wdata_o  out  64  bus write data, registered.
- bus_be_o  out  8  bus byte enables, registered; forced to 8'hFF on reads.
- bus_ack_i  in  1  single-cycle completion from the slave; sampled only while bus_req_o is high.
- bus_rdata_i  in  64  slave read data; valid with bus_ack_i.
- stall_if_o  out  1  if_req_i & ~if_ack_o.
- stall_mem_o  out  1  mem_valid_i & ~mem_ack_o.

## Operation

**States:** IDLE, BUSY_I, BUSY_D (2-bit encoding). The grant owner is implied by the state.

**IDLE, choosing a winner**
- If mem_valid_i is high and starve_cnt < STARVE_MAX → BUSY_D.
- Else if if_req_i is high → BUSY_I.
- Else if mem_valid_i is high (the counter has saturated but fetch is idle) → BUSY_D.
- Else stay in IDLE.
- On entry to either BUSY state, register the winner's fields onto bus_*_o and set bus_req_o to 1.
- Fetch always enters as a read: bus_rw_o = 0, bus_be_o = 8'hFF, bus_wdata_o = 0.

**BUSY_x**
- Hold all bus_*_o stable.
- When bus_ack_i is high:
  - Combinationally assert the owner's ack for that cycle.
  - Pass bus_rdata_i through to the owner's rdata output.
  - Clear bus_req_o and return to IDLE at the same edge.
- The non-owner's ack is always 0.
- if_rdata_o and mem_rdata_o are bus_rdata_i gated by their ack; they read 0 otherwise.

**starve_cnt (4 bits)**
- Increments on each grant to data made while if_req_i is high, saturating at STARVE_MAX.
- Clears to 0 on every fetch grant.
- Holds its value on data grants made while if_req_i is low.

**Reset** (asynchronous, mid-transaction included)
- State → IDLE; bus_req_o, bus_rw_o → 0; bus_addr_o, bus_wdata_o → 0; bus_be_o → 0; starve_cnt → 0.
- ack and rdata outputs → 0.
- stall_* follow their combinational definitions.
- An aborted transaction is not replayed; requesters re-present after reset.

**Not permitted**
- A requester dropping its request before its ack: undefined; the bench asserts against it.
- bus_ack_i in IDLE: ignored.

## Timing
- Request high at cycle N while IDLE → bus_req_o high at N+1.
- Zero-wait slave: bus_ack_i and the owner's ack at N+1; IDLE at N+2; the next grant's bus_req_o at N+3.
- Minimum back-to-back spacing: 2 cycles per transaction.
- Simultaneous requests in IDLE: data wins unless the counter is saturated.
- A request arriving during BUSY waits; its stall_* stays high.
- A requester may raise a new request in the cycle after its ack. It is evaluated in IDLE.

## Structure
- Shared package core_defs_pkg holds:
  - the state encoding constants ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D;
  - the bus width constants XLEN = 64 and BE_W = 8.
- One sub-module, arb_starve_counter: a saturating counter with inc, clr and sat outputs, parameterised by MAX.

## Test plan
- Lone fetch read: if_req_i = 1, if_addr_i = 64'h1000, bus_ack_i one cycle after bus_req_o rises → bus_addr_o = 64'h1000, bus_rw_o = 0, bus_be_o = 8'hFF; if_ack_o for 1 cycle with if_rdata_o = bus_rdata_i; stall_if_o low on that cycle.
- Data write: mem_rw_i = 1, addr 64'h2008, data 64'hDEADBEEF, byte enables 8'h0F → bus outputs match for the whole busy period; mem_ack_o only on bus_ack_i.
- Simultaneous requests, STARVE_MAX = 2, data held back-to-back → data, data, then fetch granted; counter back to 0 after the fetch grant.
- Slave wait of 5 cycles → bus_* stable for 5 cycles; stall_mem_o high throughout; single mem_ack_o.
- rst low mid BUSY_D → bus_req_o drops immediately (asynchronous); after release, IDLE with starve_cnt = 0, and a stray bus_ack_i produces no ack.
- bus_ack_i pulsed in IDLE → no ack output and no state change.
